// File: rtl/ldpc_dvb_dec_cnode_restore_mlane_pkg.sv
// Shared types for the DVB-S2 LDPC cnode restore path: node widths, the min-sum row summary,
// the row context and the normalisation mode.
package ldpc_dvb_dec_cnode_restore_mlane_pkg;

    localparam int unsigned pLLR_W  = 4;
    localparam int unsigned pNODE_W = 8;
    localparam int unsigned pLANE_N = 8;
    localparam int unsigned cCOL_W  = 5;
    localparam int unsigned cADDR_W = 8;

    typedef logic [pLLR_W-1:0]  llr_t;
    typedef logic [pNODE_W-2:0] vnode_t;
    typedef logic [pNODE_W-1:0] node_t;
    typedef logic [cCOL_W-1:0]  vn_min_col_t;

    typedef struct packed {
        vnode_t      min1;
        vnode_t      min2;
        vn_min_col_t min1_col;
        logic        prod_sign;
    } vn_min_t;

    typedef struct packed {
        logic               mask_0_bit;
        logic [cADDR_W-1:0] addr;
    } cnode_ctx_t;

    typedef enum logic [1:0] {
        PLAIN  = 2'd0,
        OFFSET = 2'd1,
        SCALE  = 2'd2,
        RSVD   = 2'd3
    } cnode_norm_mode_t;

endpackage

// File: rtl/ldpc_dvb_dec_cnode_restore_mlane_lane.sv
// One lane of the cnode restore: min select, min-sum correction, then sign-magnitude to two's complement.
module ldpc_dvb_dec_cnode_restore_lane
    import ldpc_dvb_dec_cnode_restore_mlane_pkg::*;
(
    input  logic             iclk,
    input  logic             iclkena,
    input  cnode_norm_mode_t imode,
    input  vnode_t           ioffset,
    input  vn_min_t          ivn_min,
    input  vn_min_col_t      ivnode_idx,
    input  logic             ivnode_sign,
    input  logic             ivnode_mask,
    input  logic             imask_0_bit,
    output node_t            ocnode,
    output logic             ozf
);

    vnode_t mag;
    vnode_t cmag;
    logic   sgn;
    logic   kill;

    vnode_t cmag_r;
    logic   sgn_r;
    logic   kill_r;

    // The column that supplied min1 must see min2 instead (exclude own contribution)
    always_comb begin
        mag  = (ivn_min.min1_col == ivnode_idx) ? ivn_min.min2 : ivn_min.min1;
        sgn  = ivn_min.prod_sign ^ ivnode_sign;
        kill = ivnode_mask & imask_0_bit;
        cmag = mag;
        case (imode)
            OFFSET:  cmag = (mag > ioffset) ? vnode_t'(mag - ioffset) : '0;
            SCALE:   cmag = vnode_t'(mag - (mag >> 2));
            default: cmag = mag;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (iclkena) begin
            cmag_r <= cmag;
            sgn_r  <= sgn;
            kill_r <= kill;
            ozf    <= (cmag == '0) & (mag != '0) & ~kill;
        end
    end

    // Conditional negate; a zero magnitude with sign set folds back to 0
    always_ff @(posedge iclk) begin
        if (iclkena) begin
            ocnode <= kill_r ? '0
                             : node_t'(({1'b0, cmag_r} ^ {pNODE_W{sgn_r}}) + node_t'(sgn_r));
        end
    end

endmodule

// File: rtl/ldpc_dvb_dec_cnode_restore_mlane.sv
// Multi-lane min-sum cnode restore with plain/offset/scaled normalisation, fixed 2-cycle latency,
// plus a saturating count of lanes the correction forced to zero.
module ldpc_dvb_dec_cnode_restore_mlane
    import ldpc_dvb_dec_cnode_restore_mlane_pkg::*;
#(
    parameter int unsigned pCNT_W = 16
) (
    input  logic                         iclk,
    input  logic                         ireset,
    input  logic                         iclkena,
    input  logic                         istart,
    input  logic [1:0]                   imode,
    input  logic [pNODE_W-2:0]           ioffset,
    input  logic                         ival,
    input  logic [pLANE_N*cCOL_W-1:0]    ivnode_idx,
    input  logic [pLANE_N-1:0]           ivnode_sign,
    input  logic [pLANE_N-1:0]           ivnode_mask,
    input  vn_min_t                      ivn_min,
    input  cnode_ctx_t                   icnode_ctx,
    output logic                         ocnode_val,
    output cnode_ctx_t                   ocnode_ctx,
    output logic [pLANE_N*pNODE_W-1:0]   ocnode,
    output logic [pCNT_W-1:0]            ozero_cnt
);

    localparam int unsigned cPOP_W = $clog2(pLANE_N + 1);
    localparam int unsigned cSUM_W = ((pCNT_W > cPOP_W) ? pCNT_W : cPOP_W) + 1;
    localparam logic [cSUM_W-1:0] cCNT_MAX = cSUM_W'({pCNT_W{1'b1}});

    cnode_norm_mode_t mode_r;
    cnode_norm_mode_t mode_use;
    vnode_t           offset_r;
    vnode_t           offset_use;
    logic             val1;
    cnode_ctx_t       ctx1;
    logic [pLANE_N-1:0] zf;
    logic [cPOP_W-1:0]  pop;
    logic [cSUM_W-1:0]  sum;
    logic [pCNT_W-1:0]  cnt_nxt;

    // A row arriving together with istart already uses the new settings
    assign mode_use   = istart ? cnode_norm_mode_t'(imode) : mode_r;
    assign offset_use = istart ? ioffset : offset_r;

    for (genvar l = 0; l < pLANE_N; l++) begin : g_lane
        ldpc_dvb_dec_cnode_restore_lane u_lane (
            .iclk        (iclk),
            .iclkena     (iclkena),
            .imode       (mode_use),
            .ioffset     (offset_use),
            .ivn_min     (ivn_min),
            .ivnode_idx  (ivnode_idx[l*cCOL_W +: cCOL_W]),
            .ivnode_sign (ivnode_sign[l]),
            .ivnode_mask (ivnode_mask[l]),
            .imask_0_bit (icnode_ctx.mask_0_bit),
            .ocnode      (ocnode[l*pNODE_W +: pNODE_W]),
            .ozf         (zf[l])
        );
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < int'(pLANE_N); i++) begin
            pop = pop + cPOP_W'(zf[i]);
        end
        sum     = cSUM_W'(ozero_cnt) + cSUM_W'(pop);
        cnt_nxt = (sum > cCNT_MAX) ? {pCNT_W{1'b1}} : pCNT_W'(sum);
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            val1       <= 1'b0;
            ocnode_val <= 1'b0;
            ozero_cnt  <= '0;
            mode_r     <= PLAIN;
            offset_r   <= '0;
        end else if (iclkena) begin
            val1       <= ival;
            ocnode_val <= val1;
            if (istart) begin
                mode_r    <= mode_use;
                offset_r  <= offset_use;
                ozero_cnt <= '0;
            end else if (val1) begin
                ozero_cnt <= cnt_nxt;
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (iclkena) begin
            ctx1       <= icnode_ctx;
            ocnode_ctx <= ctx1;
        end
    end

endmodule
